// File: rtl/ab_input_conditioner_pkg.sv
// Shared types and defaults for the A/B switch input conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: per-channel FSM state encoding and default parameter values.
package abcond_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic {
        ST_STABLE = 1'b0,   // synchronized input agrees with the output level
        ST_PEND   = 1'b1    // input differs; qualifying the new level
    } state_e;

    localparam int DEB_CYCLES_DEF = 4;
    localparam int CNT_W_DEF      = 8;

endpackage : abcond_pkg

// File: rtl/ab_input_conditioner_if.sv
// Signal bundle between the raw switch source and the input conditioner.
// Latency: n/a (wires only).
// Backpressure: none; levels and pulses are free-running.
// master: drives a_raw/b_raw, observes conditioned levels and edge pulses.
// slave : the conditioner; consumes raw inputs, drives A/B and pulses.
interface ab_input_conditioner_if;
    logic a_raw;
    logic b_raw;
    logic A;
    logic B;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;

    modport master (
        output a_raw, b_raw,
        input  A, B, a_rise, a_fall, b_rise, b_fall
    );

    modport slave (
        input  a_raw, b_raw,
        output A, B, a_rise, a_fall, b_rise, b_fall
    );
endinterface : ab_input_conditioner_if

// File: rtl/ab_input_conditioner_debounce_channel.sv
// One switch channel: synchronizer, debounce counter/FSM, registered edge pulses.
// Latency: raw-to-level DEB_CYCLES+3 edges with ABCOND_SYNC2_EN, else DEB_CYCLES+2.
// Backpressure: none; input sampled every cycle.
// Ports: clk, reset (async active-low), raw (async switch), level (debounced),
//        rise/fall (one-cycle pulses coincident with the new level).
// Build option: ABCOND_SYNC2_EN selects a two-flop synchronizer in front of the FSM.
module debounce_channel
    import abcond_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,  // 1..255
    parameter int CNT_W      = CNT_W_DEF        // 2**CNT_W > DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // s_q is the clock-aligned sample the FSM acts on.
    logic s_q;

`ifdef ABCOND_SYNC2_EN
    logic meta_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            s_q    <= 1'b0;
        end else begin
            meta_q <= raw;
            s_q    <= meta_q;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q <= 1'b0;
        end else begin
            s_q <= raw;
        end
    end
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The counter only counts while PENDING and is cleared on every exit,
    // so it never exceeds DEB_CYCLES and any bounce restarts from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (s_q != level_q) begin
                    state_d = ST_PEND;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PEND: begin
                if (s_q == level_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TGT) begin
                    // Qualified: commit the level and flag the edge in the same cycle.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    level_d = s_q;
                    rise_d  = s_q;
                    fall_d  = ~s_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule : debounce_channel

// File: rtl/ab_input_conditioner.sv
// Conditions raw A/B switches into clean clock-aligned levels plus edge pulses.
// Latency: DEB_CYCLES+3 edges raw-to-level with ABCOND_SYNC2_EN, else DEB_CYCLES+2.
// Backpressure: none; both channels run every cycle, independently.
// Ports: clk, reset (async active-low), io (slave side of ab_input_conditioner_if:
//        a_raw/b_raw in; A/B levels and a_/b_ rise/fall pulses out).
// Build option: ABCOND_SYNC2_EN (two-flop synchronizer per channel).
module ab_input_conditioner
    import abcond_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    ab_input_conditioner_if.slave        io
);

    debounce_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ch_a (
        .clk   (clk),
        .reset (reset),
        .raw   (io.a_raw),
        .level (io.A),
        .rise  (io.a_rise),
        .fall  (io.a_fall)
    );

    debounce_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ch_b (
        .clk   (clk),
        .reset (reset),
        .raw   (io.b_raw),
        .level (io.B),
        .rise  (io.b_rise),
        .fall  (io.b_fall)
    );

endmodule : ab_input_conditioner

// File: doc/ab_input_conditioner.md
Name: ab_input_conditioner

Overview:
- Upstream stage for the two-input FSM lab blocks. Takes raw, asynchronous, bouncy A/B switch inputs and produces clean, clock-aligned A and B levels.
- Also produces one-cycle edge pulses per channel.
- The two channels are independent and identical, so a bouncing switch never causes a spurious FSM transition.

Parameters:
- DEB_CYCLES, 4, number of consecutive clock cycles the synchronized input must differ from the current output before the output changes (legal range 1..255).
- CNT_W, 8, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- a_raw  input  1  raw switch A, asynchronous to clk
- b_raw  input  1  raw switch B, asynchronous to clk
- A  output  1  debounced level of a_raw, registered
- B  output  1  debounced level of b_raw, registered
- a_rise  output  1  one-cycle pulse when A goes 0->1
- a_fall  output  1  one-cycle pulse when A goes 1->0
- b_rise  output  1  one-cycle pulse when B goes 0->1
- b_fall  output  1  one-cycle pulse when B goes 1->0

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low (reset=0 clears immediately, with no clock edge required).
- Reset values: A=B=0, all pulses 0, synchronizer flops 0, counters 0, both channel FSMs in STABLE.
- Per channel, s is the synchronized sample of the raw input.
- Channel FSM, STABLE state: s==out; cnt held at 0. If s!=out, go to PENDING with cnt<=1.
- Channel FSM, PENDING state:
  - If s==out (glitch ended): cnt<=0, go to STABLE, out unchanged, no pulse.
  - Else if cnt==DEB_CYCLES: out<=s, cnt<=0, assert the matching rise/fall pulse for exactly that one cycle, go to STABLE.
  - Else cnt<=cnt+1.
- DEB_CYCLES=1 is legal: out follows s one edge after PENDING is entered.
- Latency: out changes exactly DEB_CYCLES+1 rising edges after the first edge at which s shows the new value, provided s stays constant throughout.
- Any bounce shorter than that restarts qualification from zero. The counter never wraps: it is bounded by DEB_CYCLES.
- Pulses are registered and coincide with the cycle in which the new out level first appears.
- Rise and fall on the same channel can never occur together.
- A and B channels change simultaneously when their inputs qualify on the same edge; there is no interaction between them.
- Reset asserted mid-PENDING: the pending change is discarded and outputs return to 0. After release, a held-high raw input requalifies with the full latency.
- No outputs depend combinationally on a_raw or b_raw.

Optional Feature:
- Macro ABCOND_SYNC2_EN.
- Defined: s passes through a two-flop synchronizer, so total raw-to-out latency is DEB_CYCLES+3 edges from the first sampling edge.
- Undefined: a single register stage feeds the FSM, so latency is DEB_CYCLES+2 edges. This mode is for lab benches driving inputs synchronously.
- Reset values are 0 in both builds.

Decomposition:
- Shared package abcond_pkg:
  - state encoding constants ST_STABLE=1'b0 and ST_PEND=1'b1
  - default DEB_CYCLES constant
- Sub-module debounce_channel (ports clk, reset, raw, level, rise, fall; parameters DEB_CYCLES, CNT_W), instantiated twice. It contains the synchronizer, counter and FSM.
- The top level only wires the two instances.

Test Plan:
All scenarios use DEB_CYCLES=4, clk period 10, ABCOND_SYNC2_EN defined.
1. Reset:
   - Stimulus: hold reset=0 with a_raw=b_raw=1 for 30 time units.
   - Required: A=B=0 and all pulses 0 throughout. Release reset; A and B rise exactly 7 edges after the first sampling edge, and a_rise and b_rise are each high for one cycle.
2. Clean step:
   - Stimulus: a_raw 0->1 held.
   - Required: A=1 after 7 edges, a_rise is a single pulse, B stays 0, b_* pulses stay 0.
   - Then a_raw 1->0: A=0 after 7 edges, with a single a_fall pulse.
3. Glitch rejection:
   - Stimulus: a_raw high for 3 cycles, then low.
   - Required: A stays 0 and no pulses occur. The counter returns to 0, checked via hierarchical access to the debounce_channel counter register.
4. Bounce:
   - Stimulus: a_raw toggles 1,0,1,0 with 1-cycle spacing, then held 1.
   - Required: exactly one a_rise, occurring 7 edges after the final settle edge. No a_fall.
5. Reset mid-qualification:
   - Stimulus: a_raw goes 1, then reset is pulsed low after 4 cycles.
   - Required: A is 0 immediately and a_rise is suppressed. After release, A=1 appears after the full 7-edge latency.
6. Simultaneous channels:
   - Stimulus: a_raw and b_raw go 0->1 on the same edge, held.
   - Required: A and B rise in the same cycle and a_rise/b_rise pulse together.
   - Rerun with the macro undefined; the required latency is 6 edges.
